// File: rtl/pixel_combinator.sv
// Raster-order reader: walks (x,y), broadcasts the check coordinate to the reorder queues,
// and emits the matching queue's colour (or a default colour after a timeout) on a valid/ready stream.
module pixel_combinator #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    RBG_SIZE       = 24,
  parameter int                    NUM_QUEUES     = 4,
  parameter int                    X_SIZE         = 640,
  parameter int                    Y_SIZE         = 480,
  parameter int                    TIMEOUT        = 1024,
  parameter logic [RBG_SIZE-1:0]   DEFAULT_COLOUR = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [NUM_QUEUES-1:0]          hit_i,
  input  logic [NUM_QUEUES*RBG_SIZE-1:0] colour_i,
  output logic [DATA_WIDTH-1:0]          xpixel_check,
  output logic [DATA_WIDTH-1:0]          ypixel_check,
  output logic [RBG_SIZE-1:0]            m_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic                           m_sof,
  output logic                           m_eol,
  output logic                           frame_done,
  output logic [15:0]                    miss_count
);

  localparam int KW = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  // PARK is all-ones minus one: never a real pixel and never the empty-slot marker.
  localparam logic [DATA_WIDTH-1:0] PARK   = {{(DATA_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [DATA_WIDTH-1:0] X_LAST = DATA_WIDTH'(X_SIZE - 1);
  localparam logic [DATA_WIDTH-1:0] Y_LAST = DATA_WIDTH'(Y_SIZE - 1);
  localparam logic [TW-1:0]         TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEEK,
    S_CAPTURE,
    S_EMIT
  } state_t;

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   x_q;
  logic [DATA_WIDTH-1:0]   y_q;
  logic [DATA_WIDTH-1:0]   xchk_q;
  logic [DATA_WIDTH-1:0]   ychk_q;
  logic [KW-1:0]           sel_q;
  logic [TW-1:0]           to_q;
  logic [RBG_SIZE-1:0]     data_q;
  logic                    valid_q;
  logic                    sof_q;
  logic                    eol_q;
  logic                    done_q;
  logic [15:0]             miss_q;

  logic [DATA_WIDTH-1:0]   x_d;
  logic [DATA_WIDTH-1:0]   y_d;
  logic                    last_d;
  logic                    sof_d;
  logic                    eol_d;
  logic                    hit_any;
  logic [KW-1:0]           hit_idx;
  logic [RBG_SIZE-1:0]     colour_arr [NUM_QUEUES];

  always_comb begin
    for (int k = 0; k < NUM_QUEUES; k++) begin
      colour_arr[k] = colour_i[k*RBG_SIZE +: RBG_SIZE];
    end
  end

  // Lowest-index hit wins when several queues match at once.
  always_comb begin
    hit_any = |hit_i;
    hit_idx = '0;
    for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
      if (hit_i[i]) hit_idx = KW'(i);
    end
  end

  always_comb begin
    sof_d  = (x_q == '0) && (y_q == '0);
    eol_d  = (x_q == X_LAST);
    last_d = (x_q == X_LAST) && (y_q == Y_LAST);
    x_d    = x_q + DATA_WIDTH'(1);
    y_d    = y_q;
    if (x_q == X_LAST) begin
      x_d = '0;
      y_d = (y_q == Y_LAST) ? '0 : y_q + DATA_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      xchk_q  <= PARK;
      ychk_q  <= PARK;
      sel_q   <= '0;
      to_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      done_q  <= 1'b0;
      miss_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          xchk_q <= PARK;
          ychk_q <= PARK;
          if (enable) begin
            x_q     <= '0;
            y_q     <= '0;
            xchk_q  <= '0;
            ychk_q  <= '0;
            to_q    <= '0;
            state_q <= S_SEEK;
          end
        end

        S_SEEK: begin
          to_q <= to_q + TW'(1);
          if (hit_any) begin
            // Parking the check on the same edge guarantees a single pop.
            sel_q   <= hit_idx;
            xchk_q  <= PARK;
            ychk_q  <= PARK;
            state_q <= S_CAPTURE;
          end else if (to_q == TO_LAST) begin
            data_q  <= DEFAULT_COLOUR;
            valid_q <= 1'b1;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            if (miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
            xchk_q  <= PARK;
            ychk_q  <= PARK;
            state_q <= S_EMIT;
          end
        end

        S_CAPTURE: begin
          // The queue's registered colour is valid one cycle after its match.
          data_q  <= colour_arr[sel_q];
          valid_q <= 1'b1;
          sof_q   <= sof_d;
          eol_q   <= eol_d;
          state_q <= S_EMIT;
        end

        S_EMIT: begin
          if (m_ready) begin
            valid_q <= 1'b0;
            to_q    <= '0;
            x_q     <= x_d;
            y_q     <= y_d;
            done_q  <= last_d;
            if (last_d && !enable) begin
              state_q <= S_IDLE;
            end else begin
              xchk_q  <= x_d;
              ychk_q  <= y_d;
              state_q <= S_SEEK;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign xpixel_check = xchk_q;
  assign ypixel_check = ychk_q;
  assign m_data       = data_q;
  assign m_valid      = valid_q;
  assign m_sof        = sof_q;
  assign m_eol        = eol_q;
  assign frame_done   = done_q;
  assign miss_count   = miss_q;

endmodule

// File: tb/tb_pixel_combinator.sv
// Bench for pixel_combinator: 4x2 frame, two queues, TIMEOUT=8; table frame, random frames, reset corners.
module tb_pixel_combinator;

  localparam int          DW   = 32;
  localparam int          RBG  = 24;
  localparam int          NQ   = 2;
  localparam int          XS   = 4;
  localparam int          YS   = 2;
  localparam int          TO   = 8;
  localparam logic [23:0] DEF  = 24'hDEF00D;
  localparam logic [31:0] PARK = 32'hFFFF_FFFE;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [NQ-1:0]     hit_i;
  logic [NQ*RBG-1:0] colour_i;
  logic [DW-1:0]     xpixel_check;
  logic [DW-1:0]     ypixel_check;
  logic [RBG-1:0]    m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_sof;
  logic              m_eol;
  logic              frame_done;
  logic [15:0]       miss_count;

  int tests = 0;
  int fails = 0;

  pixel_combinator #(
    .DATA_WIDTH(DW), .RBG_SIZE(RBG), .NUM_QUEUES(NQ), .X_SIZE(XS), .Y_SIZE(YS),
    .TIMEOUT(TO), .DEFAULT_COLOUR(DEF)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .hit_i(hit_i), .colour_i(colour_i),
    .xpixel_check(xpixel_check), .ypixel_check(ypixel_check),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_sof(m_sof), .m_eol(m_eol),
    .frame_done(frame_done), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [47:0] garbage();
    return {24'($urandom), 24'($urandom)};
  endfunction

  // Drives one pixel: queues answer after dly SEEK cycles with mask (0 = nobody answers),
  // then the sink stalls for 'stall' cycles before accepting. Entered and left on a negedge.
  task automatic serve(input string tag, input int dly, input logic [1:0] mask,
                       input logic [23:0] c0, input logic [23:0] c1, input int stall,
                       input logic [23:0] ed, input logic esof, input logic eeol,
                       input logic [31:0] ex, input logic [31:0] ey,
                       input logic efd, input logic [15:0] emiss);
    int n;
    hit_i    = '0;
    m_ready  = 1'b0;
    colour_i = garbage();
    n = 0;
    while (xpixel_check == PARK && n < 4) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " check x"}, 64'(xpixel_check), 64'(ex));
    chk({tag, " check y"}, 64'(ypixel_check), 64'(ey));
    if (mask != 2'b00) begin
      repeat (dly) @(negedge clk);
      hit_i = mask;
      @(negedge clk);
      hit_i    = '0;
      colour_i = {c1, c0};
      chk({tag, " park in capture"}, {xpixel_check, ypixel_check}, {PARK, PARK});
      @(negedge clk);
      colour_i = garbage();
    end
    n = 0;
    while (!m_valid && n < TO + 4) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " seek-to-valid cycles"}, 64'(n), (mask != 2'b00) ? 64'd0 : 64'(TO));
    chk({tag, " valid/sof/eol/data"}, {37'd0, m_valid, m_sof, m_eol, m_data},
        {37'd0, 1'b1, esof, eeol, ed});
    chk({tag, " miss_count"}, 64'(miss_count), 64'(emiss));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, " stall hold"}, {37'd0, m_valid, m_sof, m_eol, m_data},
          {37'd0, 1'b1, esof, eeol, ed});
      chk({tag, " stall park"}, {xpixel_check, ypixel_check}, {PARK, PARK});
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk({tag, " frame_done"}, 64'(frame_done), 64'(efd));
    chk({tag, " valid dropped"}, 64'(m_valid), 64'd0);
  endtask

  typedef struct {
    int          dly;
    logic [1:0]  mask;
    logic [23:0] c0;
    logic [23:0] c1;
    int          stall;
    logic [23:0] ed;
    logic        esof;
    logic        eeol;
    logic [31:0] ex;
    logic [31:0] ey;
    logic        efd;
    logic [15:0] emiss;
  } vec_t;

  vec_t vec [8];

  initial begin
    int          p;
    int          x;
    int          y;
    int          dly;
    int          stall;
    logic [1:0]  mask;
    logic [23:0] c0;
    logic [23:0] c1;
    logic [23:0] ed;
    logic [15:0] model_miss;

    vec[0] = '{1, 2'b10, 24'h000001, 24'hABCDEF, 0, 24'hABCDEF, 1'b1, 1'b0, 0, 0, 1'b0, 16'd0};
    vec[1] = '{0, 2'b01, 24'h123456, 24'h654321, 5, 24'h123456, 1'b0, 1'b0, 1, 0, 1'b0, 16'd0};
    vec[2] = '{0, 2'b00, 24'h0, 24'h0, 0, DEF, 1'b0, 1'b0, 2, 0, 1'b0, 16'd1};
    vec[3] = '{2, 2'b11, 24'h111111, 24'h222222, 1, 24'h111111, 1'b0, 1'b1, 3, 0, 1'b0, 16'd1};
    vec[4] = '{0, 2'b10, 24'h999999, 24'h0F0F0F, 0, 24'h0F0F0F, 1'b0, 1'b0, 0, 1, 1'b0, 16'd1};
    vec[5] = '{3, 2'b01, 24'hA5A5A5, 24'h5A5A5A, 2, 24'hA5A5A5, 1'b0, 1'b0, 1, 1, 1'b0, 16'd1};
    vec[6] = '{0, 2'b00, 24'h0, 24'h0, 0, DEF, 1'b0, 1'b0, 2, 1, 1'b0, 16'd2};
    vec[7] = '{0, 2'b11, 24'h333333, 24'h444444, 0, 24'h333333, 1'b0, 1'b1, 3, 1, 1'b1, 16'd2};

    reset    = 1'b0;
    enable   = 1'b0;
    m_ready  = 1'b0;
    hit_i    = '0;
    colour_i = '0;
    repeat (3) @(negedge clk);
    chk("reset check", {xpixel_check, ypixel_check}, {PARK, PARK});
    chk("reset stream", {37'd0, m_valid, m_sof, m_eol, m_data}, 64'd0);
    chk("reset done/miss", {47'd0, frame_done, miss_count}, 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle park", {xpixel_check, ypixel_check}, {PARK, PARK});

    // Hand-written frame; enable drops after the first pixel but the frame must finish.
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      serve($sformatf("vec%0d", i), vec[i].dly, vec[i].mask, vec[i].c0, vec[i].c1, vec[i].stall,
            vec[i].ed, vec[i].esof, vec[i].eeol, vec[i].ex, vec[i].ey, vec[i].efd, vec[i].emiss);
      if (i == 0) enable = 1'b0;
    end
    @(negedge clk);
    chk("frame_done single pulse", 64'(frame_done), 64'd0);
    repeat (3) begin
      chk("idle after frame", {xpixel_check, ypixel_check}, {PARK, PARK});
      @(negedge clk);
    end

    // Random frames against a raster model: pixel p lives at (p mod X, (p div X) mod Y).
    model_miss = 16'd2;
    enable = 1'b1;
    for (p = 0; p < 3 * XS * YS; p++) begin
      x     = p % XS;
      y     = (p / XS) % YS;
      dly   = $urandom_range(0, 5);
      mask  = 2'($urandom_range(0, 3));
      c0    = 24'($urandom);
      c1    = 24'($urandom);
      stall = $urandom_range(0, 3);
      if (mask[0])      ed = c0;
      else if (mask[1]) ed = c1;
      else begin
        ed = DEF;
        if (model_miss != 16'hFFFF) model_miss = model_miss + 16'd1;
      end
      serve($sformatf("rnd%0d", p), dly, mask, c0, c1, stall, ed,
            (x == 0 && y == 0), (x == XS - 1), 32'(x), 32'(y),
            (p % (XS * YS)) == (XS * YS - 1), model_miss);
    end

    // Reset while a pixel is waiting in EMIT with the sink stalled.
    hit_i = 2'b01;
    @(negedge clk);
    hit_i    = '0;
    colour_i = {24'h0, 24'h555555};
    @(negedge clk);
    chk("pre-reset pixel valid", 64'(m_valid), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid reset valid", 64'(m_valid), 64'd0);
    chk("mid reset check", {xpixel_check, ypixel_check}, {PARK, PARK});
    chk("mid reset miss", 64'(miss_count), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    serve("restart", 0, 2'b01, 24'h777777, 24'h888888, 0, 24'h777777, 1'b1, 1'b0,
          32'd0, 32'd0, 1'b0, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pixel_combinator.md
Name: pixel_combinator

Overview:
Raster-order reader for the per-engine reorder queues. It walks pixel coordinates in raster order (x fastest) and drives each coordinate as the check coordinate to every queue. When a queue's front entry matches, the queue pops. The block captures that queue's colour and emits it on a valid/ready pixel stream with start-of-frame and end-of-line markers; this stream feeds the video output stage. If no queue produces a coordinate within a bounded time, a default colour is substituted so the frame cannot stall forever.

Parameters:
DATA_WIDTH, 32, coordinate width (matches the queues)
RBG_SIZE, 24, colour width
NUM_QUEUES, 4, number of queues attached
X_SIZE, 640, pixels per line
Y_SIZE, 480, lines per frame
TIMEOUT, 1024, cycles in SEEK without a hit before a miss
DEFAULT_COLOUR, 24'h000000, colour emitted on a miss

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low; 0 = reset
enable  input  1  start/continue frames; sampled in IDLE and at end of frame
hit_i  input  NUM_QUEUES  bit k = queue k's front matches the current check coordinate (same cycle)
colour_i  input  NUM_QUEUES*RBG_SIZE  queue k's colour_o in slice [k*RBG_SIZE +: RBG_SIZE]
xpixel_check  output  DATA_WIDTH  registered check x broadcast to all queues
ypixel_check  output  DATA_WIDTH  registered check y broadcast to all queues
m_data  output  RBG_SIZE  pixel colour
m_valid  output  1  pixel valid
m_ready  input  1  downstream ready
m_sof  output  1  qualifies m_data: pixel (0,0)
m_eol  output  1  qualifies m_data: x == X_SIZE-1
frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted
miss_count  output  16  saturating count of timed-out pixels; cleared only by reset

Behaviour:
- Reset (asynchronous assert, synchronous release) sets the following:
  - state = IDLE; internal x = 0, y = 0
  - xpixel_check = ypixel_check = PARK, where PARK = all-ones minus 1. PARK never matches a real coordinate or the all-ones empty-slot marker in the queues.
  - m_data = 0, m_valid = 0, m_sof = 0, m_eol = 0, frame_done = 0, miss_count = 0, timeout counter = 0
- IDLE:
  - check outputs = PARK.
  - If enable = 1, go to SEEK with x = y = 0 and check loaded with (0,0).
- SEEK:
  - check outputs hold (x,y). The timeout counter increments each cycle.
  - If any hit_i bit is set, latch the lowest set index k. Load check = PARK on the same edge so that only one queue pops exactly once. Go to CAPTURE.
  - Otherwise, if the timeout counter reaches TIMEOUT-1:
    - m_data <= DEFAULT_COLOUR, m_valid <= 1, miss_count increments (saturating at 16'hFFFF), check <= PARK
    - go to EMIT
- CAPTURE:
  - Exactly one cycle, because the queue's registered colour_o is valid the cycle after the match.
  - m_data <= colour_i slice k, m_valid <= 1. Go to EMIT.
  - hit_i is ignored in this state.
- m_sof and m_eol are set together with m_valid, derived from the current (x,y).
- EMIT:
  - m_data, m_sof, m_eol and m_valid hold stable while m_ready = 0.
  - On m_valid & m_ready: m_valid <= 0, the timeout counter clears, and the coordinate advances:
    - x+1 if x < X_SIZE-1;
    - else x = 0, y+1;
    - at (X_SIZE-1, Y_SIZE-1), wrap to (0,0) and pulse frame_done the next cycle.
  - Next state after the handshake:
    - end of frame and enable = 0 → IDLE;
    - otherwise → SEEK with check = new (x,y).
- Throughput: at most one pixel per 3 cycles (SEEK, CAPTURE, EMIT) with m_ready held high.
- Arithmetic: coordinates are unsigned DATA_WIDTH; comparisons are against X_SIZE-1 and Y_SIZE-1. The timeout counter width is $clog2(TIMEOUT)+1.
- Simultaneous hits: the lowest index wins. The others popped too; their pixels are lost and this is not counted as a miss. This is a protocol violation upstream and must not hang the block.
- enable deasserted mid-frame: the frame completes; enable is checked only at frame end.
- Reset mid-operation: all state returns to reset values within the same cycle. A partially emitted pixel is dropped (m_valid = 0).

Test Plan:
1. X_SIZE=4, Y_SIZE=2, NUM_QUEUES=2, m_ready=1. Enable=1; queue 1 asserts hit_i=2'b10 one cycle after check=(0,0), then colour_i[47:24]=24'hABCDEF → m_data=24'hABCDEF with m_sof=1 two cycles after the hit; check=PARK during CAPTURE; next check=(1,0).
2. Backpressure: hold m_ready=0 for 5 cycles while m_valid=1 → m_data, m_sof and m_eol stable; check stays PARK; no advance until m_ready=1.
3. Timeout, TIMEOUT=8: no hits at (2,0) → after 8 SEEK cycles, m_data=DEFAULT_COLOUR, miss_count=1, next check=(3,0).
4. Wrap: serve all 8 pixels → m_eol=1 on (3,0) and (3,1); frame_done pulses once after (3,1) is accepted; with enable=0 the state returns to IDLE and check=PARK.
5. Simultaneous hit_i=2'b11 with colour_i slices 24'h111111 and 24'h222222 → m_data=24'h111111; block continues to the next coordinate.
6. Assert reset=0 during EMIT with m_ready=0 → m_valid=0, check=PARK and miss_count=0 immediately. After release with enable=1, restart at (0,0) with m_sof=1 on the first pixel.
